// File: rtl/bus_memory_pkg.sv
// ============================================================================
//  Module      : bus_memory_pkg
//  Description : Shared constants, address-field positions and FSM state
//                encoding for the bus memory responder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bus_memory_pkg;

  localparam int PAGE_BITS  = 4;
  localparam int WORD_BITS  = 4;
  localparam int INDEX_BITS = 8;

  // Byte-address field positions
  localparam int ADDR_WORD_LSB  = 2;
  localparam int ADDR_WORD_MSB  = 5;
  localparam int ADDR_PAGE_LSB  = 6;
  localparam int ADDR_PAGE_MSB  = 9;
  localparam int ADDR_RANGE_LSB = 10;
  localparam int ADDR_RANGE_MSB = 31;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

endpackage

`default_nettype wire

// File: rtl/bus_memory_responder_if.sv
// ============================================================================
//  Module      : bus_memory_responder_if
//  Description : Bus-multiplexer to memory-responder signal bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bus_memory_responder_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  memory_read;
  logic                  memory_write;
  logic [31:0]           memory_address;
  logic [DATA_WIDTH-1:0] memory_write_data;
  logic [DATA_WIDTH-1:0] memory_read_data;
  logic                  busy;
  logic                  error;

  modport master (
    output memory_read,
    output memory_write,
    output memory_address,
    output memory_write_data,
    input  memory_read_data,
    input  busy,
    input  error
  );

  modport slave (
    input  memory_read,
    input  memory_write,
    input  memory_address,
    input  memory_write_data,
    output memory_read_data,
    output busy,
    output error
  );
endinterface

`default_nettype wire

// File: rtl/bus_memory_array.sv
// ============================================================================
//  Module      : bus_memory_array
//  Description : Single-port synchronous RAM, registered read-before-write.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_memory_array #(
  parameter int DEPTH      = 256,
  parameter int IDX_BITS   = 8,
  parameter int DATA_WIDTH = 32
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  input  wire logic                  i_we,
  input  wire logic                  i_re,
  input  wire logic [IDX_BITS-1:0]   i_idx,
  input  wire logic [DATA_WIDTH-1:0] i_wdata,
  output logic      [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_idx] <= i_wdata;
    end
  end

  // Same-edge read samples the pre-write contents
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_idx];
    end
  end

  assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/bus_memory_responder.sv
// ============================================================================
//  Module      : bus_memory_responder
//  Description : Memory responder below the bus multiplexer: post-reset zero
//                fill, word read/write, sticky illegal-access flag.
//                Optional access counters enabled by BUS_MEMORY_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_memory_responder
  import bus_memory_pkg::*;
#(
  parameter int PAGES          = 16,
  parameter int WORDS_PER_PAGE = 16,
  parameter int DATA_WIDTH     = 32
) (
  input  wire logic          clk,
  input  wire logic          reset,
  bus_memory_responder_if.slave bus
`ifdef BUS_MEMORY_STATS_EN
  ,
  output logic [15:0]        read_count,
  output logic [15:0]        write_count
`endif
);

  localparam int                C_DEPTH    = PAGES * WORDS_PER_PAGE;
  localparam int                C_IDX_BITS = $clog2(C_DEPTH);
  localparam logic [C_IDX_BITS-1:0] C_LAST_IDX = C_IDX_BITS'(C_DEPTH - 1);

  state_e                  r_state;
  logic [C_IDX_BITS-1:0]   r_clr_idx;
  logic                    r_busy;
  logic                    r_error;

  logic                    w_range_err;
  logic                    w_misalign;
  logic                    w_strobe;
  logic                    w_accept;
  logic                    w_ram_we;
  logic                    w_ram_re;
  logic [C_IDX_BITS-1:0]   w_ram_idx;
  logic [DATA_WIDTH-1:0]   w_ram_wdata;
  logic [C_IDX_BITS-1:0]   w_index;

  assign w_index     = bus.memory_address[C_IDX_BITS+ADDR_WORD_LSB-1:ADDR_WORD_LSB];
  assign w_range_err = |bus.memory_address[ADDR_RANGE_MSB:C_IDX_BITS+ADDR_WORD_LSB];
  assign w_misalign  = |bus.memory_address[ADDR_WORD_LSB-1:0];
  assign w_strobe    = bus.memory_read | bus.memory_write;
  assign w_accept    = (r_state == ST_READY) && !w_range_err;

  // The clear sweep owns the RAM port until it finishes
  always_comb begin
    w_ram_we    = 1'b0;
    w_ram_re    = 1'b0;
    w_ram_idx   = w_index;
    w_ram_wdata = bus.memory_write_data;
    if (r_state == ST_CLEAR) begin
      w_ram_we    = 1'b1;
      w_ram_idx   = r_clr_idx;
      w_ram_wdata = '0;
    end else begin
      w_ram_we = w_accept & bus.memory_write;
      w_ram_re = w_accept & bus.memory_read;
    end
  end

  bus_memory_array #(
    .DEPTH      (C_DEPTH),
    .IDX_BITS   (C_IDX_BITS),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_array (
    .clk     (clk),
    .rst_n   (reset),
    .i_we    (w_ram_we),
    .i_re    (w_ram_re),
    .i_idx   (w_ram_idx),
    .i_wdata (w_ram_wdata),
    .o_rdata (bus.memory_read_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_CLEAR;
      r_clr_idx <= '0;
      r_busy    <= 1'b1;
      r_error   <= 1'b0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          if (w_strobe) begin
            r_error <= 1'b1;
          end
          if (r_clr_idx == C_LAST_IDX) begin
            r_state <= ST_READY;
            r_busy  <= 1'b0;
          end else begin
            r_clr_idx <= r_clr_idx + 1'b1;
          end
        end
        ST_READY: begin
          if (w_strobe && (w_range_err || w_misalign)) begin
            r_error <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_CLEAR;
        end
      endcase
    end
  end

  assign bus.busy  = r_busy;
  assign bus.error = r_error;

`ifdef BUS_MEMORY_STATS_EN
  logic [15:0] r_read_count;
  logic [15:0] r_write_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_read_count  <= '0;
      r_write_count <= '0;
    end else begin
      if (w_accept && bus.memory_read && (r_read_count != 16'hFFFF)) begin
        r_read_count <= r_read_count + 16'd1;
      end
      if (w_accept && bus.memory_write && (r_write_count != 16'hFFFF)) begin
        r_write_count <= r_write_count + 16'd1;
      end
    end
  end

  assign read_count  = r_read_count;
  assign write_count = r_write_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bus_memory_responder.sv
// ============================================================================
//  Module      : tb_bus_memory_responder
//  Description : Directed self-checking bench for bus_memory_responder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_memory_responder;
  import bus_memory_pkg::*;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;
  int   n;

  bus_memory_responder_if #(.DATA_WIDTH(32)) bus ();

`ifdef BUS_MEMORY_STATS_EN
  logic [15:0] read_count;
  logic [15:0] write_count;
`endif

  bus_memory_responder #(
    .PAGES          (16),
    .WORDS_PER_PAGE (16),
    .DATA_WIDTH     (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
`ifdef BUS_MEMORY_STATS_EN
    ,
    .read_count  (read_count),
    .write_count (write_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
    bus.memory_write      = 1'b1;
    bus.memory_address    = addr;
    bus.memory_write_data = data;
    tick();
    bus.memory_write      = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr);
    bus.memory_read    = 1'b1;
    bus.memory_address = addr;
    tick();
    bus.memory_read    = 1'b0;
  endtask

  // Counts edges until busy falls, optionally pulsing a read strobe mid-clear
  task automatic wait_clear(input int strobe_at, output int cycles);
    cycles = 0;
    while (bus.busy && cycles < 400) begin
      bus.memory_read = (cycles == strobe_at);
      tick();
      cycles++;
    end
    bus.memory_read = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset                 = 1'b0;
    bus.memory_read       = 1'b0;
    bus.memory_write      = 1'b0;
    bus.memory_address    = 32'h0;
    bus.memory_write_data = 32'h0;
    repeat (3) tick();

    check("reset_rdata", bus.memory_read_data, 32'h0);
    check("reset_busy",  {31'h0, bus.busy},  32'h1);
    check("reset_error", {31'h0, bus.error}, 32'h0);

    reset = 1'b1;
    wait_clear(-1, n);
    check("clear_cycles", n, 32'd256);
    check("busy_after_clear", {31'h0, bus.busy}, 32'h0);

    do_read(32'h3FC);
    check("read_3fc_zero", bus.memory_read_data, 32'h0);

    do_write(32'h014, 32'hDEADBEEF);
    check("write_keeps_rdata", bus.memory_read_data, 32'h0);
    do_read(32'h014);
    check("read_014", bus.memory_read_data, 32'hDEADBEEF);
    do_read(32'h054);
    check("page_isolation_054", bus.memory_read_data, 32'h0);

    do_write(32'h020, 32'h22222222);
    bus.memory_read       = 1'b1;
    bus.memory_write      = 1'b1;
    bus.memory_address    = 32'h020;
    bus.memory_write_data = 32'h11111111;
    tick();
    bus.memory_read       = 1'b0;
    bus.memory_write      = 1'b0;
    check("rbw_old_value", bus.memory_read_data, 32'h22222222);
    do_read(32'h020);
    check("rbw_new_value", bus.memory_read_data, 32'h11111111);
    check("rbw_no_error", {31'h0, bus.error}, 32'h0);

    do_write(32'h400, 32'h99999999);
    check("range_err_set", {31'h0, bus.error}, 32'h1);
    do_read(32'h000);
    check("range_no_alias", bus.memory_read_data, 32'h0);

    do_write(32'h004, 32'hCAFEF00D);
    do_read(32'h006);
    check("misaligned_read", bus.memory_read_data, 32'hCAFEF00D);
    check("error_sticky", {31'h0, bus.error}, 32'h1);
    do_write(32'h004, 32'h12345678);
    check("rdata_hold", bus.memory_read_data, 32'hCAFEF00D);

    // Reset in the middle of the clear sweep
    do_write(32'h0F0, 32'h5A5A5A5A);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    repeat (100) tick();
    check("busy_mid_clear", {31'h0, bus.busy}, 32'h1);
    reset = 1'b0;
    #1;
    check("rst_rdata", bus.memory_read_data, 32'h0);
    check("rst_error", {31'h0, bus.error}, 32'h0);
    tick();
    reset = 1'b1;
    wait_clear(10, n);
    check("reclear_cycles", n, 32'd256);
    check("strobe_in_clear_err", {31'h0, bus.error}, 32'h1);
    check("strobe_in_clear_rdata", bus.memory_read_data, 32'h0);

    do_write(32'h3FC, 32'hA5A5A5A5);
    do_read(32'h3FC);
    check("post_clear_write", bus.memory_read_data, 32'hA5A5A5A5);
    do_read(32'h014);
    check("cleared_014", bus.memory_read_data, 32'h0);
    do_read(32'h020);
    check("cleared_020", bus.memory_read_data, 32'h0);
    do_read(32'h0F0);
    check("cleared_0f0", bus.memory_read_data, 32'h0);
    do_read(32'h004);
    check("cleared_004", bus.memory_read_data, 32'h0);

`ifdef BUS_MEMORY_STATS_EN
    reset = 1'b0;
    tick();
    reset = 1'b1;
    wait_clear(-1, n);
    check("stats_clear_cycles", n, 32'd256);
    bus.memory_write      = 1'b1;
    bus.memory_address    = 32'h008;
    bus.memory_write_data = 32'h1;
    repeat (3) tick();
    check("write_count_3", {16'h0, write_count}, 32'h3);
    repeat (69997) tick();
    bus.memory_write = 1'b0;
    check("write_count_sat", {16'h0, write_count}, 32'hFFFF);
    check("read_count_zero", {16'h0, read_count}, 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
